// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive-side FIFO.
// The default widths are shared with the receiver, the transmitter and the tx-side FIFO.
package uart_rx_fifo_pkg;

  localparam int UART_DBIT    = 8;
  localparam int UART_FIFO_AW = 4;

  // The encoding is {write_effective, read_effective}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Host-facing bundle of the receive FIFO: write strobe and byte from the receiver,
// pop and error-clear strobes from the consumer, and the status and data it reads back.
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int DBIT       = UART_DBIT,
  parameter int ADDR_WIDTH = UART_FIFO_AW
);

  logic                  rx_done_tick;
  logic [DBIT-1:0]       din;
  logic                  rd;
  logic                  clr_err;
  logic [DBIT-1:0]       r_data;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overrun;

  modport master (
    output rx_done_tick, din, rd, clr_err,
    input  r_data, empty, full, count, overrun
  );

  modport slave (
    input  rx_done_tick, din, rd, clr_err,
    output r_data, empty, full, count, overrun
  );

endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// Pointer, count and empty/full bookkeeping for a circular FIFO.
// Used by both the receive-side and the transmit-side FIFOs.
module fifo_ctrl
  import uart_rx_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = UART_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] w_ptr_reg, w_ptr_next;
  logic [ADDR_WIDTH-1:0] r_ptr_reg, r_ptr_next;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  wr_eff;
  logic                  rd_eff;
  fifo_op_e              op;

  // A write into a full FIFO only lands when a read frees the head slot in the same cycle.
  assign wr_eff = wr & (~full | rd);
  assign rd_eff = rd & ~empty;
  assign op     = fifo_op_e'({wr_eff, rd_eff});

  always_comb begin
    w_ptr_next = w_ptr_reg;
    r_ptr_next = r_ptr_reg;
    count_next = count_reg;
    case (op)
      OP_WR: begin
        w_ptr_next = w_ptr_reg + PTR_ONE;
        count_next = count_reg + CNT_ONE;
      end
      OP_RD: begin
        r_ptr_next = r_ptr_reg + PTR_ONE;
        count_next = count_reg - CNT_ONE;
      end
      OP_BOTH: begin
        w_ptr_next = w_ptr_reg + PTR_ONE;
        r_ptr_next = r_ptr_reg + PTR_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_reg <= '0;
      r_ptr_reg <= '0;
      count_reg <= '0;
    end else begin
      w_ptr_reg <= w_ptr_next;
      r_ptr_reg <= r_ptr_next;
      count_reg <= count_next;
    end
  end

  // Flags decode straight from the registered count so they can never disagree with it.
  assign empty  = (count_reg == '0);
  assign full   = (count_reg == CNT_MAX);
  assign count  = count_reg;
  assign w_addr = w_ptr_reg;
  assign r_addr = r_ptr_reg;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer: captures bytes on the receiver's done strobe into a
// first-word-fall-through FIFO and keeps a sticky flag for bytes dropped while full.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DBIT       = UART_DBIT,
  parameter int ADDR_WIDTH = UART_FIFO_AW
) (
  input  logic         clk,
  input  logic         reset,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DBIT-1:0]       mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_eff;
  logic                  overrun_set;
  logic                  overrun_reg;

  fifo_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.rx_done_tick),
    .rd     (bus.rd),
    .w_addr (w_addr),
    .r_addr (r_addr),
    .empty  (empty),
    .full   (full),
    .count  (count)
  );

  assign wr_eff = bus.rx_done_tick & (~full | bus.rd);

  // Storage is deliberately not reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (wr_eff) begin
      mem[w_addr] <= bus.din;
    end
  end

  assign overrun_set = bus.rx_done_tick & full & ~bus.rd;

  // A new drop outranks a simultaneous clear so the event is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (overrun_set) begin
      overrun_reg <= 1'b1;
    end else if (bus.clr_err) begin
      overrun_reg <= 1'b0;
    end
  end

  assign bus.r_data  = mem[r_addr];
  assign bus.empty   = empty;
  assign bus.full    = full;
  assign bus.count   = count;
  assign bus.overrun = overrun_reg;

endmodule
